// File: rtl/cellrv32_cpu_cp_cond_x_if.sv
// Execute-stage co-processor bus for the conditional-operations unit.
// master = CPU issue side, slave = co-processor.
interface cellrv32_cpu_cp_cond_x_if #(
    parameter int unsigned XLEN = 32
);
    logic            start_i;
    logic            kill_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic [XLEN-1:0] res_o;
    logic            valid_o;
    logic            busy_o;
    logic            err_o;

    modport master (
        output start_i, kill_i, op_i, rs1_i, rs2_i,
        input  res_o, valid_o, busy_o, err_o
    );

    modport slave (
        input  start_i, kill_i, op_i, rs1_i, rs2_i,
        output res_o, valid_o, busy_o, err_o
    );
endinterface

// File: rtl/cellrv32_cpu_cp_cond_x.sv
// Zicond czero.eqz/nez co-processor with fixed latency; min/max/minu/maxu
// are built only when CELLRV32_CP_COND_MINMAX_EN is defined, else reserved.
module cellrv32_cpu_cp_cond_x #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned LATENCY = 1
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    cellrv32_cpu_cp_cond_x_if.slave   bus
);
    localparam int unsigned CNT_W = 3;

    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $error("cellrv32_cpu_cp_cond_x: LATENCY must be within 1..8");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [2:0]      r_op;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;

    logic            w_capture;
    logic [2:0]      w_op;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic [XLEN-1:0] w_res_calc;
    logic            w_err_calc;

    logic [XLEN-1:0] r_res;
    logic            r_valid;
    logic            r_busy;
    logic            r_err;
    logic [XLEN-1:0] w_res_nxt;
    logic            w_valid_nxt;
    logic            w_busy_nxt;
    logic            w_err_nxt;

    assign w_capture = (r_state == S_IDLE) && bus.start_i && !bus.kill_i;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_op  <= '0;
            r_rs1 <= '0;
            r_rs2 <= '0;
        end else if (w_capture) begin
            r_op  <= bus.op_i;
            r_rs1 <= bus.rs1_i;
            r_rs2 <= bus.rs2_i;
        end
    end

    // Counter reaches zero on entry to DONE, so DONE lands LATENCY cycles after start.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_capture) begin
                    w_cnt_nxt   = CNT_W'(LATENCY - 1);
                    w_state_nxt = (LATENCY == 1) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.kill_i) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Single-cycle ops reach DONE at the capture edge, so compute from the live inputs then.
    assign w_op = (r_state == S_IDLE) ? bus.op_i  : r_op;
    assign w_a  = (r_state == S_IDLE) ? bus.rs1_i : r_rs1;
    assign w_b  = (r_state == S_IDLE) ? bus.rs2_i : r_rs2;

`ifdef CELLRV32_CP_COND_MINMAX_EN
    logic w_lt;
    assign w_lt = w_op[0] ? (w_a < w_b) : ($signed(w_a) < $signed(w_b));
`endif

    always_comb begin
        w_res_calc = '0;
        w_err_calc = 1'b0;
        case (w_op)
            3'b000: w_res_calc = (w_b == '0) ? '0 : w_a;
            3'b001: w_res_calc = (w_b != '0) ? '0 : w_a;
`ifdef CELLRV32_CP_COND_MINMAX_EN
            3'b100, 3'b101: w_res_calc = w_lt ? w_a : w_b;
            3'b110, 3'b111: w_res_calc = w_lt ? w_b : w_a;
`endif
            default: w_err_calc = 1'b1;
        endcase
    end

    // Result bus is OR-merged, so everything but busy is zero outside DONE.
    always_comb begin
        w_valid_nxt = (w_state_nxt == S_DONE);
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_res_nxt   = w_valid_nxt ? w_res_calc : '0;
        w_err_nxt   = w_valid_nxt && w_err_calc;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_res   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_res   <= w_res_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign bus.res_o   = r_res;
    assign bus.valid_o = r_valid;
    assign bus.busy_o  = r_busy;
    assign bus.err_o   = r_err;
endmodule

// File: tb/tb_cellrv32_cpu_cp_cond_x.sv
// Directed bench for cellrv32_cpu_cp_cond_x across LATENCY 1/2/3/4 and XLEN 64;
// min/max expectations follow CELLRV32_CP_COND_MINMAX_EN.
module tb_cellrv32_cpu_cp_cond_x;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    cellrv32_cpu_cp_cond_x_if #(.XLEN(32)) if1 ();
    cellrv32_cpu_cp_cond_x_if #(.XLEN(32)) if2 ();
    cellrv32_cpu_cp_cond_x_if #(.XLEN(32)) if3 ();
    cellrv32_cpu_cp_cond_x_if #(.XLEN(32)) if4 ();
    cellrv32_cpu_cp_cond_x_if #(.XLEN(64)) if64 ();

    cellrv32_cpu_cp_cond_x #(.XLEN(32), .LATENCY(1)) u1  (.clk_i(clk), .rstn_i(rstn), .bus(if1));
    cellrv32_cpu_cp_cond_x #(.XLEN(32), .LATENCY(2)) u2  (.clk_i(clk), .rstn_i(rstn), .bus(if2));
    cellrv32_cpu_cp_cond_x #(.XLEN(32), .LATENCY(3)) u3  (.clk_i(clk), .rstn_i(rstn), .bus(if3));
    cellrv32_cpu_cp_cond_x #(.XLEN(32), .LATENCY(4)) u4  (.clk_i(clk), .rstn_i(rstn), .bus(if4));
    cellrv32_cpu_cp_cond_x #(.XLEN(64), .LATENCY(1)) u64 (.clk_i(clk), .rstn_i(rstn), .bus(if64));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // LATENCY=1: result one cycle after start, then back to idle.
    task automatic run1(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic ee);
        if1.op_i = op; if1.rs1_i = a; if1.rs2_i = b; if1.start_i = 1'b1;
        tick();
        if1.start_i = 1'b0;
        chk({tag, ".valid"}, 64'(if1.valid_o), 64'd1);
        chk({tag, ".busy"},  64'(if1.busy_o),  64'd1);
        chk({tag, ".res"},   64'(if1.res_o),   64'(er));
        chk({tag, ".err"},   64'(if1.err_o),   64'(ee));
        tick();
        chk({tag, ".valid_after"}, 64'(if1.valid_o), 64'd0);
        chk({tag, ".res_after"},   64'(if1.res_o),   64'd0);
    endtask

    // LATENCY=3: busy N+1..N+3, valid only at N+3.
    task automatic run3(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic ee);
        if3.op_i = op; if3.rs1_i = a; if3.rs2_i = b; if3.start_i = 1'b1;
        tick();
        if3.start_i = 1'b0;
        chk({tag, ".n1.busy"},  64'(if3.busy_o),  64'd1);
        chk({tag, ".n1.valid"}, 64'(if3.valid_o), 64'd0);
        chk({tag, ".n1.res"},   64'(if3.res_o),   64'd0);
        tick();
        chk({tag, ".n2.busy"},  64'(if3.busy_o),  64'd1);
        chk({tag, ".n2.valid"}, 64'(if3.valid_o), 64'd0);
        tick();
        chk({tag, ".n3.busy"},  64'(if3.busy_o),  64'd1);
        chk({tag, ".n3.valid"}, 64'(if3.valid_o), 64'd1);
        chk({tag, ".n3.res"},   64'(if3.res_o),   64'(er));
        chk({tag, ".n3.err"},   64'(if3.err_o),   64'(ee));
        tick();
        chk({tag, ".n4.busy"},  64'(if3.busy_o),  64'd0);
        chk({tag, ".n4.valid"}, 64'(if3.valid_o), 64'd0);
    endtask

    initial begin
        int pulses;
        if1.start_i = 0;  if1.kill_i = 0;  if1.op_i = 0;  if1.rs1_i = 0;  if1.rs2_i = 0;
        if2.start_i = 0;  if2.kill_i = 0;  if2.op_i = 0;  if2.rs1_i = 0;  if2.rs2_i = 0;
        if3.start_i = 0;  if3.kill_i = 0;  if3.op_i = 0;  if3.rs1_i = 0;  if3.rs2_i = 0;
        if4.start_i = 0;  if4.kill_i = 0;  if4.op_i = 0;  if4.rs1_i = 0;  if4.rs2_i = 0;
        if64.start_i = 0; if64.kill_i = 0; if64.op_i = 0; if64.rs1_i = 0; if64.rs2_i = 0;

        rstn = 1'b0;
        repeat (3) tick();
        chk("rst.valid", 64'(if1.valid_o), 64'd0);
        chk("rst.busy",  64'(if1.busy_o),  64'd0);
        chk("rst.res",   64'(if1.res_o),   64'd0);
        chk("rst.err",   64'(if1.err_o),   64'd0);
        rstn = 1'b1;
        tick();

        // czero on LATENCY=1
        run1("eqz_z",  3'b000, 32'hDEADBEEF, 32'd0, 32'd0,         1'b0);
        run1("eqz_nz", 3'b000, 32'hDEADBEEF, 32'd5, 32'hDEADBEEF, 1'b0);
        run1("nez_z",  3'b001, 32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 1'b0);
        run1("nez_nz", 3'b001, 32'hDEADBEEF, 32'd5, 32'd0,         1'b0);

        // kill together with start in IDLE: nothing happens
        if1.op_i = 3'b001; if1.rs1_i = 32'h1234; if1.rs2_i = 0;
        if1.start_i = 1'b1; if1.kill_i = 1'b1;
        tick();
        if1.start_i = 1'b0; if1.kill_i = 1'b0;
        chk("killstart.valid", 64'(if1.valid_o), 64'd0);
        chk("killstart.busy",  64'(if1.busy_o),  64'd0);
        chk("killstart.res",   64'(if1.res_o),   64'd0);

        // min/max on LATENCY=3
`ifdef CELLRV32_CP_COND_MINMAX_EN
        run3("min",  3'b100, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 1'b0);
        run3("minu", 3'b101, 32'hFFFFFFFF, 32'd1, 32'd1,        1'b0);
        run3("max",  3'b110, 32'hFFFFFFFF, 32'd1, 32'd1,        1'b0);
        run3("maxu", 3'b111, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 1'b0);
        run3("min_eq", 3'b100, 32'h00000007, 32'h7, 32'h7,      1'b0);
`else
        run3("min",  3'b100, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);
        run3("minu", 3'b101, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);
        run3("max",  3'b110, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);
        run3("maxu", 3'b111, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);
`endif

        // kill at N+1 on LATENCY=3, then a new start at N+2 finishing at N+5
        if3.op_i = 3'b000; if3.rs1_i = 32'hA5A5A5A5; if3.rs2_i = 32'd1; if3.start_i = 1'b1;
        tick();
        if3.start_i = 1'b0; if3.kill_i = 1'b1;
        tick();
        if3.kill_i = 1'b0;
        chk("kill.n2.busy",  64'(if3.busy_o),  64'd0);
        chk("kill.n2.valid", 64'(if3.valid_o), 64'd0);
        if3.op_i = 3'b001; if3.rs1_i = 32'h55; if3.rs2_i = 32'd0; if3.start_i = 1'b1;
        tick();
        if3.start_i = 1'b0;
        chk("kill.n3.valid", 64'(if3.valid_o), 64'd0);
        chk("kill.n3.busy",  64'(if3.busy_o),  64'd1);
        tick();
        chk("kill.n4.valid", 64'(if3.valid_o), 64'd0);
        tick();
        chk("kill.n5.valid", 64'(if3.valid_o), 64'd1);
        chk("kill.n5.res",   64'(if3.res_o),   64'h55);
        tick();

        // overlapping start on LATENCY=4 is ignored
        if4.op_i = 3'b000; if4.rs1_i = 32'h11111111; if4.rs2_i = 32'd1; if4.start_i = 1'b1;
        tick();
        if4.start_i = 1'b0;
        tick();
        if4.op_i = 3'b001; if4.rs1_i = 32'h22222222; if4.rs2_i = 32'd0; if4.start_i = 1'b1;
        tick();
        if4.start_i = 1'b0;
        chk("ovl.n3.valid", 64'(if4.valid_o), 64'd0);
        tick();
        chk("ovl.n4.valid", 64'(if4.valid_o), 64'd1);
        chk("ovl.n4.res",   64'(if4.res_o),   64'h11111111);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (if4.valid_o === 1'b1) pulses++;
        end
        chk("ovl.extra_pulses", 64'(pulses), 64'd0);
        chk("ovl.idle_busy",    64'(if4.busy_o), 64'd0);

        // reset mid-operation on LATENCY=2
        if2.op_i = 3'b001; if2.rs1_i = 32'h7; if2.rs2_i = 32'd0; if2.start_i = 1'b1;
        tick();
        if2.start_i = 1'b0; rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("rstmid.valid", 64'(if2.valid_o), 64'd0);
        chk("rstmid.busy",  64'(if2.busy_o),  64'd0);
        chk("rstmid.res",   64'(if2.res_o),   64'd0);
        chk("rstmid.err",   64'(if2.err_o),   64'd0);
        tick();
        chk("rstmid.after", 64'(if2.valid_o), 64'd0);

        // reserved op 010 on LATENCY=2
        if2.op_i = 3'b010; if2.rs1_i = 32'hCAFE; if2.rs2_i = 32'd3; if2.start_i = 1'b1;
        tick();
        if2.start_i = 1'b0;
        chk("rsv.n1.valid", 64'(if2.valid_o), 64'd0);
        chk("rsv.n1.err",   64'(if2.err_o),   64'd0);
        tick();
        chk("rsv.n2.valid", 64'(if2.valid_o), 64'd1);
        chk("rsv.n2.err",   64'(if2.err_o),   64'd1);
        chk("rsv.n2.res",   64'(if2.res_o),   64'd0);
        tick();

        // XLEN=64 czero
        if64.op_i = 3'b001; if64.rs1_i = 64'h8000000000000001; if64.rs2_i = 64'd0; if64.start_i = 1'b1;
        tick();
        if64.start_i = 1'b0;
        chk("x64.nez.valid", 64'(if64.valid_o), 64'd1);
        chk("x64.nez.res",   if64.res_o,         64'h8000000000000001);
        tick();
        if64.op_i = 3'b000; if64.rs2_i = 64'h1_0000_0000; if64.start_i = 1'b1;
        tick();
        if64.start_i = 1'b0;
        chk("x64.eqz.res",   if64.res_o,         64'h8000000000000001);
        tick();
        chk("x64.idle.res",  if64.res_o,         64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
